counter_sweep_scheduler: RTL and testbench
==========================================

Name: counter_sweep_scheduler

Overview:
- Shares one internal WIDTH-bit up/down sweep counter between NREQ requesters using round-robin arbitration.
- Each request carries a window (lo, hi) and a leg count. The granted job sweeps the counter lo->hi->lo... for that many monotonic legs, then reports done.
- Sits between control masters and the display/stimulus path that consumes the count value.

Parameters:
- WIDTH, 4, counter and bound width (unsigned).
- NREQ, 2, number of requesters (>=2).
- LW, 4, width of the per-request leg count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request; held high until gnt bit seen.
- req_lo  in  NREQ*WIDTH  lower bound; requester i at bits [i*WIDTH +: WIDTH].
- req_hi  in  NREQ*WIDTH  upper bound, same packing.
- req_legs  in  NREQ*LW  number of legs, packed at [i*LW +: LW].
- abort  in  1  synchronous abort of the running job.
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
- err  out  1  one-cycle pulse: accepted request rejected as invalid.
- busy  out  1  job running.
- count  out  WIDTH  counter value.
- dir  out  1  0 = counting up, 1 = counting down.
- done  out  1  one-cycle pulse, job completed.
- done_id  out  $clog2(NREQ)  index of the requester whose job finished/aborted; holds until next completion.
- aborted  out  1  one-cycle pulse, job aborted.

Behaviour:
- Reset (async): count=0, dir=0, busy=0, gnt=0, err=done=aborted=0, done_id=0, state IDLE, rr pointer=0 (requester 0 highest priority).
- States: IDLE, RUN. All outputs registered.
- IDLE arbitration: search req starting at rr pointer, wrapping; winner k. On the clock edge:
  - gnt[k]=1 for one cycle.
  - Pointer becomes (k+1) mod NREQ.
- Validity check: lo<hi and legs!=0.
  - Invalid: err=1 same cycle as gnt; stay IDLE; count/dir unchanged.
  - Valid: count<=lo, dir<=0, leg counter<=0, busy<=1, state RUN; window/legs/k latched.
  - Requester inputs may change after gnt.
- RUN, each edge:
  - dir=0: count+1. dir=1: count-1.
  - An edge where the new count equals hi (up) or lo (down) ends a leg: leg counter+1.
  - If that was the last leg: state IDLE, busy<=0, done=1, done_id=k; count holds the final value and dir is unchanged.
  - Otherwise dir toggles on that same edge.
- Job timing: legs*(hi-lo) RUN edges. Final count = hi if legs is odd, lo if even.
- No wrap-around possible: count always stays within [lo, hi].
- A new request can be granted on the edge right after done (IDLE entered).
- Requests arriving during RUN are ignored until IDLE; no gnt during RUN.
- abort:
  - In RUN: state IDLE, busy<=0, aborted=1, done_id=k, done stays 0, count/dir hold.
  - In IDLE: ignored.
  - abort and final-leg edge coincide: abort wins (aborted=1, done=0).
- Reset mid-run: immediate return to reset values; latched job discarded; no pulses.

Test Plan:
- WIDTH=4; req0 lo=0 hi=15 legs=2 -> gnt=01, then count 0,1..15 (dir flips to 1 at 15), 14..0; done pulse with count=0, done_id=0, 30 RUN cycles.
- req0 lo=3 hi=7 legs=1 -> count 3,4,5,6,7; done after 4 RUN edges, count holds 7, dir=0, busy falls with done.
- req0 and req1 both high from reset, legs=1 -> gnt=01 first; after done, gnt=10 next edge; then req0 again (rr alternation).
- req1 lo=5 hi=5 -> gnt=10 and err=1 same cycle, busy stays 0, count unchanged; next pending req0 granted the following edge.
- Running lo=2 hi=9 legs=3, abort at count=6 going up -> aborted=1, done=0, count holds 6, busy=0.
- Assert rst at count=8 mid-run -> count=0, busy=0, dir=0 immediately; no done/aborted pulse; req0 gets priority after release.

Source files
------------

// File: rtl/counter_sweep_scheduler.sv
// Round-robin scheduler that shares one up/down sweep counter between NREQ requesters.
// Each granted job sweeps the counter between its window bounds for a given number of legs.
module counter_sweep_scheduler #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned LW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_lo,
  input  logic [NREQ*WIDTH-1:0]    req_hi,
  input  logic [NREQ*LW-1:0]       req_legs,
  input  logic                     abort,
  output logic [NREQ-1:0]          gnt,
  output logic                     err,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic                     dir,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     aborted
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [LW-1:0]     legs_q, legs_d, legcnt_q, legcnt_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              dir_q, dir_d, busy_q, busy_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              err_q, err_d, done_q, done_d, aborted_q, aborted_d;
  logic [IW-1:0]     done_id_q, done_id_d;

  // Rotating-priority search starting at the round-robin pointer.
  logic              found;
  logic [IW-1:0]     win;
  always_comb begin
    int unsigned j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr_q) + i) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  logic [WIDTH-1:0] sel_lo, sel_hi;
  logic [LW-1:0]    sel_legs;
  logic             sel_valid;
  assign sel_lo    = req_lo[32'(win)*WIDTH +: WIDTH];
  assign sel_hi    = req_hi[32'(win)*WIDTH +: WIDTH];
  assign sel_legs  = req_legs[32'(win)*LW +: LW];
  assign sel_valid = (sel_lo < sel_hi) && (sel_legs != '0);

  logic [WIDTH-1:0] cnt_step;
  logic             leg_end;
  logic [LW-1:0]    leg_inc;
  assign cnt_step = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
  assign leg_end  = dir_q ? (cnt_step == lo_q) : (cnt_step == hi_q);
  assign leg_inc  = legcnt_q + LW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    legs_d    = legs_q;
    legcnt_d  = legcnt_q;
    count_d   = count_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_id_d = done_id_q;
    gnt_d     = '0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d = NREQ'(1) << win;
          ptr_d = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
          if (sel_valid) begin
            state_d  = StRun;
            id_d     = win;
            lo_d     = sel_lo;
            hi_d     = sel_hi;
            legs_d   = sel_legs;
            legcnt_d = '0;
            count_d  = sel_lo;
            dir_d    = 1'b0;
            busy_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          // Abort takes precedence over a coinciding final-leg edge.
          state_d   = StIdle;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          done_id_d = id_q;
        end else begin
          count_d = cnt_step;
          if (leg_end) begin
            if (leg_inc == legs_q) begin
              state_d   = StIdle;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              done_id_d = id_q;
            end else begin
              legcnt_d = leg_inc;
              dir_d    = ~dir_q;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      id_q      <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      legs_q    <= '0;
      legcnt_q  <= '0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      gnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      legs_q    <= legs_d;
      legcnt_q  <= legcnt_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign dir     = dir_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_counter_sweep_scheduler.sv
// Directed bench for counter_sweep_scheduler: sweeps, round-robin, invalid windows, abort, reset.
module tb_counter_sweep_scheduler;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned LW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_lo, req_hi;
  logic [NREQ*LW-1:0]    req_legs;
  logic                  abort;
  logic [NREQ-1:0]       gnt;
  logic                  err, busy, dir, done, aborted;
  logic [WIDTH-1:0]      count;
  logic [0:0]            done_id;

  int n_pass  = 0;
  int n_total = 0;

  counter_sweep_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .LW(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lo(req_lo), .req_hi(req_hi),
    .req_legs(req_legs), .abort(abort), .gnt(gnt), .err(err), .busy(busy),
    .count(count), .dir(dir), .done(done), .done_id(done_id), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_lo = '0; req_hi = '0; req_legs = '0; abort = 1'b0;
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_done_id", 32'(done_id), 0);
    tick();
    rst = 1'b0;
    tick();

    // Full-range window, two legs: 0..15..0 in 30 RUN edges.
    req_lo = {4'd0, 4'd0}; req_hi = {4'd0, 4'd15}; req_legs = {4'd0, 4'd2}; req = 2'b01;
    tick();
    check("a_gnt", 32'(gnt), 32'b01);
    check("a_start", 32'(count), 0);
    check("a_busy", 32'(busy), 1);
    req = 2'b00;
    for (int n = 1; n <= 30; n++) begin
      tick();
      check("a_count", 32'(count), (n <= 15) ? n : 30 - n);
      check("a_dir", 32'(dir), (n >= 15) ? 1 : 0);
      check("a_done", 32'(done), (n == 30) ? 1 : 0);
      check("a_busy_run", 32'(busy), (n == 30) ? 0 : 1);
    end
    check("a_done_id", 32'(done_id), 0);
    tick();
    check("a_done_pulse", 32'(done), 0);

    // Single leg 3..7: done after 4 edges, count holds 7, dir stays 0.
    req_lo = {4'd0, 4'd3}; req_hi = {4'd0, 4'd7}; req_legs = {4'd0, 4'd1}; req = 2'b01;
    tick();
    check("b_gnt", 32'(gnt), 32'b01);
    check("b_start", 32'(count), 3);
    req = 2'b00;
    for (int n = 1; n <= 4; n++) begin
      tick();
      check("b_count", 32'(count), 3 + n);
      check("b_done", 32'(done), (n == 4) ? 1 : 0);
    end
    check("b_busy", 32'(busy), 0);
    check("b_dir", 32'(dir), 0);
    tick();
    check("b_hold", 32'(count), 7);

    // Fresh reset, both requesting: round-robin alternation 0,1,0.
    rst = 1'b1; #2; rst = 1'b0;
    req_lo = {4'd3, 4'd3}; req_hi = {4'd4, 4'd4}; req_legs = {4'd1, 4'd1}; req = 2'b11;
    tick();
    check("rr_gnt0", 32'(gnt), 32'b01);
    req = 2'b10;
    tick();
    check("rr_done0", 32'(done), 1);
    check("rr_done_id0", 32'(done_id), 0);
    check("rr_no_gnt_run", 32'(gnt), 0);
    req = 2'b11;
    tick();
    check("rr_gnt1", 32'(gnt), 32'b10);
    check("rr_busy1", 32'(busy), 1);
    req = 2'b01;
    tick();
    check("rr_done_id1", 32'(done_id), 1);
    tick();
    check("rr_gnt0b", 32'(gnt), 32'b01);
    req = 2'b00;
    tick();
    check("rr_done_id0b", 32'(done_id), 0);
    check("rr_count", 32'(count), 4);

    // Invalid window on requester 1 (lo==hi): err with gnt, then requester 0 served.
    req_lo = {4'd5, 4'd3}; req_hi = {4'd5, 4'd7}; req_legs = {4'd1, 4'd1}; req = 2'b11;
    tick();
    check("e_gnt", 32'(gnt), 32'b10);
    check("e_err", 32'(err), 1);
    check("e_busy", 32'(busy), 0);
    check("e_count", 32'(count), 4);
    req = 2'b01;
    tick();
    check("e_gnt0", 32'(gnt), 32'b01);
    check("e_err_pulse", 32'(err), 0);
    check("e_count0", 32'(count), 3);
    req = 2'b00;
    repeat (4) tick();
    check("e_done", 32'(done), 1);

    // Abort while going up at count 6.
    req_lo = {4'd0, 4'd2}; req_hi = {4'd0, 4'd9}; req_legs = {4'd0, 4'd3}; req = 2'b01;
    tick();
    req = 2'b00;
    repeat (4) tick();
    check("ab_pre", 32'(count), 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_aborted", 32'(aborted), 1);
    check("ab_done", 32'(done), 0);
    check("ab_count", 32'(count), 6);
    check("ab_busy", 32'(busy), 0);
    check("ab_done_id", 32'(done_id), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle_ignored", 32'(aborted), 0);

    // Abort coinciding with the final-leg edge wins.
    req_lo = {4'd0, 4'd3}; req_hi = {4'd0, 4'd4}; req_legs = {4'd0, 4'd1}; req = 2'b01;
    tick();
    req = 2'b00;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abf_aborted", 32'(aborted), 1);
    check("abf_done", 32'(done), 0);
    check("abf_count", 32'(count), 3);

    // Reset mid-run at count 8 (pointer left at 1 before reset).
    req_lo = {4'd0, 4'd2}; req_hi = {4'd0, 4'd9}; req_legs = {4'd0, 4'd3}; req = 2'b01;
    tick();
    req = 2'b00;
    repeat (6) tick();
    check("r_pre", 32'(count), 8);
    rst = 1'b1;
    #1;
    check("r_count", 32'(count), 0);
    check("r_busy", 32'(busy), 0);
    check("r_dir", 32'(dir), 0);
    tick();
    check("r_no_done", 32'(done), 0);
    check("r_no_abort", 32'(aborted), 0);
    rst = 1'b0;
    req_lo = {4'd3, 4'd3}; req_hi = {4'd4, 4'd4}; req_legs = {4'd1, 4'd1}; req = 2'b11;
    tick();
    check("r_gnt_prio", 32'(gnt), 32'b01);
    req = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
